// File: rtl/ula_md_pkg.sv
// ============================================================================
// Module   : ula_md_pkg
// Brief    : Shared types and helpers for the RV64M multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ula_md_pkg;

    localparam int MD_WIDTH = 64;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } md_state_t;

    // MUL only keeps the low half, which is sign-agnostic, so it runs unsigned.
    function automatic logic op_a_signed(input md_op_t op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_b_signed(input md_op_t op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ula_mul_div_if.sv
// ============================================================================
// Module   : ula_mul_div_if
// Brief    : Request/response bundle between the control FSM and the M unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ula_mul_div_if #(
    parameter int WIDTH = 64
);
    logic             START;
    logic [2:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;
    logic             DIV_ZERO;

    modport master (
        output START, OP, A, B,
        input  BUSY, DONE, RESULT, DIV_ZERO
    );

    modport slave (
        input  START, OP, A, B,
        output BUSY, DONE, RESULT, DIV_ZERO
    );
endinterface

`default_nettype wire

// File: rtl/ula_md_core.sv
// ============================================================================
// Module   : ula_md_core
// Brief    : Unsigned one-bit-per-cycle shift-add multiplier / restoring divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ula_md_core #(
    parameter int WIDTH = 64
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_start,
    input  wire logic               i_run,
    input  wire logic               i_is_div,
    input  wire logic [WIDTH-1:0]   i_a,
    input  wire logic [WIDTH-1:0]   i_b,
    output logic                    o_last,
    output logic [2*WIDTH-1:0]      o_raw
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_trial;
    logic             w_take;

    assign w_add   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_shl   = {r_acc, r_lo[WIDTH-1]};
    assign w_trial = w_shl - {1'b0, r_b};
    // The partial remainder stays below the divisor, so bit WIDTH is a true sign.
    assign w_take  = ~w_trial[WIDTH];

    assign o_last = (r_cnt == CW'(WIDTH-1));
    assign o_raw  = {r_acc, r_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_lo     <= i_a;
            r_b      <= i_b;
            r_cnt    <= '0;
            r_is_div <= i_is_div;
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
                r_acc <= w_take ? w_trial[WIDTH-1:0] : w_shl[WIDTH-1:0];
                r_lo  <= {r_lo[WIDTH-2:0], w_take};
            end else begin
                r_acc <= w_add[WIDTH:1];
                r_lo  <= {w_add[0], r_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ula_mul_div.sv
// ============================================================================
// Module   : ula_mul_div
// Brief    : RV64M multicycle multiply/divide unit: FSM, sign fix-up, result select.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ula_mul_div
    import ula_md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ula_mul_div_if.slave    bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_FIX  = FIX;
    localparam logic [1:0] ST_FIN  = FIN;

    logic [1:0]       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] r_result;
    md_op_t           r_op;
    logic             r_a_neg;
    logic             r_b_neg;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_a;

    md_op_t             w_op;
    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_last;
    logic [2*WIDTH-1:0] w_raw;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_result;
    logic               w_dz;

    assign w_op     = md_op_t'(bus.OP);
    assign w_accept = bus.START && ((r_state == ST_IDLE) || (r_state == ST_FIN));
    assign w_a_neg  = op_a_signed(w_op) & bus.A[WIDTH-1];
    assign w_b_neg  = op_b_signed(w_op) & bus.B[WIDTH-1];
    // Negating the most-negative value wraps to 2^(WIDTH-1), the correct magnitude.
    assign w_a_mag  = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag  = w_b_neg ? -bus.B : bus.B;

    ula_md_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_accept),
        .i_run    (r_state == ST_CALC),
        .i_is_div (bus.OP[2]),
        .i_a      (w_a_mag),
        .i_b      (w_b_mag),
        .o_last   (w_last),
        .o_raw    (w_raw)
    );

    assign w_prod_s = (r_a_neg ^ r_b_neg) ? -w_raw : w_raw;
    assign w_quo_s  = (r_a_neg ^ r_b_neg) ? -w_raw[WIDTH-1:0] : w_raw[WIDTH-1:0];
    assign w_rem_s  = r_a_neg ? -w_raw[2*WIDTH-1:WIDTH] : w_raw[2*WIDTH-1:WIDTH];
    assign w_dz     = r_op[2] & r_b_zero;

    always_comb begin
        w_result = w_prod_s[WIDTH-1:0];
        case (r_op)
            MULH, MULHSU, MULHU: w_result = w_prod_s[2*WIDTH-1:WIDTH];
            DIV, DIVU:           w_result = r_b_zero ? {WIDTH{1'b1}} : w_quo_s;
            REM, REMU:           w_result = r_b_zero ? r_a : w_rem_s;
            default:             w_result = w_prod_s[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
            r_op     <= MUL;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (w_accept) begin
                        r_op     <= w_op;
                        r_a_neg  <= w_a_neg;
                        r_b_neg  <= w_b_neg;
                        r_b_zero <= (bus.B == '0);
                        r_a      <= bus.A;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (w_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_result;
                    r_dz     <= w_dz;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_FIN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.BUSY     = r_busy;
    assign bus.DONE     = r_done;
    assign bus.RESULT   = r_result;
    assign bus.DIV_ZERO = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_ula_mul_div.sv
// ============================================================================
// Module   : tb_ula_mul_div
// Brief    : Directed vector table plus multicycle corner sequences for ula_mul_div.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ula_mul_div;
    import ula_md_pkg::*;

    localparam int c_LAT = 66;
    localparam int c_NV  = 20;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        dz;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    ula_mul_div_if #(.WIDTH(64)) bus ();

    ula_mul_div #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where DONE is high.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          output int lat);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.START = 1'b0;
        lat = 1;
        while (!bus.DONE && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vecs [c_NV];
    int   lat;
    int   n;
    int   dcount;

    initial begin
        vecs = '{
            '{MUL,    64'd7,                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0},
            '{MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0},
            '{MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1'b0},
            '{MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0},
            '{DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFD, 1'b0},
            '{REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0},
            '{DIVU,   64'd100,                64'd7,                  64'd14,                  1'b0},
            '{REMU,   64'd100,                64'd7,                  64'd2,                   1'b0},
            '{DIVU,   64'h1234,               64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1},
            '{REM,    64'h1234,               64'd0,                  64'h1234,                1'b1},
            '{DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0},
            '{REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1'b0},
            '{MUL,    64'h1_0000_0000,         64'h1_0000_0000,         64'h0,                  1'b0},
            '{MULHU,  64'h1_0000_0000,         64'h1_0000_0000,         64'h1,                  1'b0},
            '{MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0},
            '{DIV,    64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0},
            '{REM,    64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 64'd1,                   1'b0},
            '{DIV,    64'hFFFF_FFFF_FFFF_EDCC, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1},
            '{REMU,   64'd5,                  64'd0,                  64'd5,                   1'b1},
            '{REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd0,                  64'hFFFF_FFFF_FFFF_FFF9, 1'b1}
        };

        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.OP    = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        check("reset BUSY",     {63'd0, bus.BUSY},     64'd0);
        check("reset DONE",     {63'd0, bus.DONE},     64'd0);
        check("reset RESULT",   bus.RESULT,            64'd0);
        check("reset DIV_ZERO", {63'd0, bus.DIV_ZERO}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < c_NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d latency", i),  64'(lat), 64'(c_LAT));
            check($sformatf("vec%0d RESULT", i),   bus.RESULT, vecs[i].res);
            check($sformatf("vec%0d DIV_ZERO", i), {63'd0, bus.DIV_ZERO}, {63'd0, vecs[i].dz});
            check($sformatf("vec%0d BUSY@DONE", i), {63'd0, bus.BUSY}, 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d DONE pulse", i), {63'd0, bus.DONE}, 64'd0);
            check($sformatf("vec%0d RESULT hold", i), bus.RESULT, vecs[i].res);
        end

        // A second START mid-operation must not disturb the DIVU in flight.
        bus.START = 1'b1; bus.OP = DIVU; bus.A = 64'd100; bus.B = 64'd7;
        @(negedge clk);
        bus.START = 1'b0;
        n = 1;
        while (!bus.DONE && n < 200) begin
            if (n == 10) begin
                bus.START = 1'b1; bus.OP = MUL; bus.A = 64'd5; bus.B = 64'd5;
            end else begin
                bus.START = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.START = 1'b0;
        check("ignored START latency", 64'(n), 64'(c_LAT));
        check("ignored START RESULT",  bus.RESULT, 64'd14);
        check("ignored START BUSY",    {63'd0, bus.BUSY}, 64'd0);

        // Back-to-back: START presented in the FIN cycle of a MULHU.
        @(negedge clk);
        run_op(MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        check("b2b first latency", 64'(lat), 64'(c_LAT));
        check("b2b first RESULT",  bus.RESULT, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(REMU, 64'd100, 64'd7, lat);
        check("b2b second latency", 64'(lat), 64'(c_LAT));
        check("b2b second RESULT",  bus.RESULT, 64'd2);

        // Asynchronous reset 30 cycles into an operation.
        @(negedge clk);
        bus.START = 1'b1; bus.OP = DIVU; bus.A = 64'h1234; bus.B = 64'd0;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (29) @(negedge clk);
        check("pre-reset BUSY", {63'd0, bus.BUSY}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset BUSY",     {63'd0, bus.BUSY},     64'd0);
        check("mid reset DONE",     {63'd0, bus.DONE},     64'd0);
        check("mid reset RESULT",   bus.RESULT,            64'd0);
        check("mid reset DIV_ZERO", {63'd0, bus.DIV_ZERO}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.DONE || bus.BUSY) dcount++;
        end
        check("idle after reset", 64'(dcount), 64'd0);

        run_op(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat);
        check("post-reset latency", 64'(lat), 64'(c_LAT));
        check("post-reset RESULT",  bus.RESULT, 64'hFFFF_FFFF_FFFF_FFEB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
